vgm_nes_player: RTL and testbench
=================================

// Module: vgm_nes_player
// PURPOSE
//  VGM command-stream interpreter driving the NES APU register-write port. Consumes VGM bytes over a
//  valid/ready stream, decodes APU writes (0xB4 aa dd) and waits, emits one-register-at-a-time write
//  strobes (reg/val/wr) paced to 44.1 kHz sample time. Sits between VGM byte source (ROM/FIFO) and APU.
// PARAMETERS
//  CLK_PER_SAMPLE  40  core clocks per VGM sample (1.79 MHz / 44.1 kHz ~= 40); must be >= 2
//  WR_PULSE        2   cycles out_wr held high, then held low, per register write; >= 1
// PORTS
//  in_clk     in   1   core clock, all logic on posedge
//  in_rst     in   1   reset, asynchronous, active-high
//  in_enable  in   1   0 = pause: no bytes consumed, wait/prescaler frozen, pending wr pulse completes
//  in_data    in   8   VGM stream byte
//  in_valid   in   1   in_data valid
//  out_ready  out  1   byte accepted on cycle with in_valid & out_ready
//  out_reg    out  4   APU register index
//  out_val    out  8   APU register value
//  out_wr     out  1   write strobe; APU latches on its rising edge
//  out_done   out  1   sticky: 0x66 end-of-stream reached
//  out_error  out  1   sticky: unsupported opcode seen
// BEHAVIOUR
//  Reset (async): state FETCH_OP, out_ready/out_wr/out_done/out_error=0, out_reg=0, out_val=0, counters 0.
//  FSM (vgm_pkg::state_t): FETCH_OP, FETCH_A0, FETCH_A1, WR_HI, WR_LO, WAIT, DONE, ERROR.
//  out_ready=1 only in FETCH_OP/FETCH_A0/FETCH_A1 with in_enable=1; registered-state decode, 1 byte/cycle max.
//  FETCH_OP: 0xB4 -> FETCH_A0(addr) -> FETCH_A1(data); 0x61 -> FETCH_A0(lo) -> FETCH_A1(hi);
//   0x66 -> DONE; any other -> ERROR (see CONFIGURATION for 0x62/0x63/0x7n).
//  0xB4 aa dd: aa<=0x0F -> out_reg=aa[3:0], out_val=dd loaded on dd accept, next cycle WR_HI.
//   aa>=0x10 (e.g. 0x15,0x17) silently dropped: no strobe, back to FETCH_OP.
//  WR_HI: out_wr=1 for WR_PULSE cycles; WR_LO: out_wr=0 for WR_PULSE cycles, then FETCH_OP.
//   out_reg/out_val stable from WR_HI entry to WR_LO exit. Accept-of-dd to out_wr rise: 1 cycle.
//  0x61 lo hi: N={hi,lo} samples (16 bit). N=0 -> FETCH_OP next cycle, no WAIT state. Else WAIT:
//   prescaler counts CLK_PER_SAMPLE cycles per sample; leave after exactly N*CLK_PER_SAMPLE cycles.
//  Prescaler reset to 0 on WAIT entry (waits do not carry phase). N=0xFFFF no overflow (16-bit down count).
//  DONE/ERROR: terminal, out_ready=0, out_wr=0; left only by reset. out_done/out_error sticky.
//  in_enable=0: in WR_HI/WR_LO pulse runs to completion then FSM holds in FETCH_OP; WAIT frozen.
//  in_valid=0 while fetching: state holds, no timeout. in_data ignored when out_ready=0.
//  Reset mid-write: out_wr drops asynchronously; partial command discarded.
// CONFIGURATION
//  VGM_NES_SHORT_WAIT_EN defined: 0x62 = wait 735, 0x63 = wait 882, 0x7n = wait n+1 samples
//   (single byte, straight to WAIT). Undefined: 0x62/0x63/0x7n -> ERROR like any unknown opcode.
// STRUCTURE
//  vgm_pkg: state_t enum, opcode constants (OP_NES_APU=8'hB4, OP_WAIT_N=8'h61, OP_WAIT_60=8'h62,
//   OP_WAIT_50=8'h63, OP_END=8'h66, OP_WAIT_SHORT_HI=4'h7), SAMPLES_60HZ=735, SAMPLES_50HZ=882.
//  Sub-module vgm_sample_tick: prescaler, inputs clear/enable, 1-cycle tick every CLK_PER_SAMPLE.
//  Top: FSM, arg latches, 16-bit sample down-counter, pulse counter.
// TESTING
//  B4 02 5A 66, params default -> one out_wr rise, out_reg=2, out_val=0x5A, high 2 cyc; then out_done=1.
//  B4 15 0F B4 00 BF -> only one strobe (reg 0, val 0xBF); 0x15 dropped, out_error=0.
//  61 03 00 B4 01 11, CLK_PER_SAMPLE=4 -> strobe rises 12 cycles after WAIT entry (+1), 61 00 00 no delay.
//  Opcode 0x50 -> out_error=1, out_ready=0 forever; reset clears; 0x62 same unless VGM_NES_SHORT_WAIT_EN,
//   then 735*CLK_PER_SAMPLE cycle wait; 0x70 waits 1 sample.
//  Async reset asserted mid WR_HI -> out_wr=0 same cycle; in_enable=0 during WAIT extends wait exactly.
//  Randomized in_valid gaps on 20-command stream -> strobe sequence identical to gapless run.

Source files
------------

// File: rtl/vgm_pkg.sv
// Shared types and constants for the VGM-to-NES-APU player.
// Optional feature macro: VGM_NES_SHORT_WAIT_EN (single-byte wait opcodes 0x62/0x63/0x7n).
package vgm_pkg;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_A0,
        FETCH_A1,
        WR_HI,
        WR_LO,
        WAIT,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0]  OP_NES_APU       = 8'hB4;
    localparam logic [7:0]  OP_WAIT_N        = 8'h61;
    localparam logic [7:0]  OP_WAIT_60       = 8'h62;
    localparam logic [7:0]  OP_WAIT_50       = 8'h63;
    localparam logic [7:0]  OP_END           = 8'h66;
    localparam logic [3:0]  OP_WAIT_SHORT_HI = 4'h7;

    localparam logic [15:0] SAMPLES_60HZ     = 16'd735;
    localparam logic [15:0] SAMPLES_50HZ     = 16'd882;

    // True for the single-byte wait opcodes (only honoured when the short-wait build is enabled).
    function automatic logic is_short_wait(input logic [7:0] op);
        return (op == OP_WAIT_60) || (op == OP_WAIT_50) || (op[7:4] == OP_WAIT_SHORT_HI);
    endfunction

    // Sample count for a single-byte wait opcode; 0x7n waits n+1 samples.
    function automatic logic [15:0] short_wait_samples(input logic [7:0] op);
        logic [15:0] n;
        case (op)
            OP_WAIT_60: n = SAMPLES_60HZ;
            OP_WAIT_50: n = SAMPLES_50HZ;
            default:    n = {12'd0, op[3:0]} + 16'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vgm_nes_player_if.sv
// Byte-stream input and APU register-write port of the VGM player.
// slave = the player itself, master = byte source / APU side.
interface vgm_nes_player_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] out_reg;
    logic [7:0] out_val;
    logic       out_wr;

    modport master (
        output in_data, in_valid,
        input  out_ready, out_reg, out_val, out_wr
    );

    modport slave (
        input  in_data, in_valid,
        output out_ready, out_reg, out_val, out_wr
    );
endinterface

// File: rtl/vgm_sample_tick.sv
// Sample-rate prescaler: one-cycle tick every CLK_PER_SAMPLE enabled cycles.
// clear forces the phase back to zero so each wait starts from a fresh sample boundary.
module vgm_sample_tick #(
    parameter int CLK_PER_SAMPLE = 40
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SAMPLE - 1);

    logic [CW-1:0] count;

    // Count enabled cycles modulo CLK_PER_SAMPLE; frozen while enable is low.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/vgm_nes_player.sv
// VGM command-stream interpreter driving the NES APU register-write port.
// Decodes 0xB4 aa dd register writes and 0x61 waits, paces output to the sample clock.
// Optional feature macro: VGM_NES_SHORT_WAIT_EN enables the single-byte waits 0x62/0x63/0x7n.
module vgm_nes_player
    import vgm_pkg::*;
#(
    parameter int CLK_PER_SAMPLE = 40,
    parameter int WR_PULSE       = 2
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_enable,
    vgm_nes_player_if.slave         bus,
    output logic                    out_done,
    output logic                    out_error
);
    localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(WR_PULSE - 1);

    state_t        state;
    state_t        state_next;
    logic          is_wait;
    logic [7:0]    arg0;
    logic [15:0]   sample_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          fetching;
    logic          accept;
    logic          tick;

    assign fetching      = (state == FETCH_OP) || (state == FETCH_A0) || (state == FETCH_A1);
    assign bus.out_ready = fetching && in_enable && !in_rst;
    assign accept        = bus.out_ready && bus.in_valid;
    assign bus.out_wr    = (state == WR_HI);
    assign out_done      = (state == DONE);
    assign out_error     = (state == ERROR);

    vgm_sample_tick #(
        .CLK_PER_SAMPLE (CLK_PER_SAMPLE)
    ) u_tick (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .clear  (state != WAIT),
        .enable (in_enable && (state == WAIT)),
        .tick   (tick)
    );

    // State register; reset discards any partially fetched command.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= FETCH_OP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode of opcodes, arguments, write pulse phases and waits.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_OP: begin
                if (accept) begin
                    case (bus.in_data)
                        OP_NES_APU,
                        OP_WAIT_N: state_next = FETCH_A0;
                        OP_END:    state_next = DONE;
                        default: begin
                            state_next = ERROR;
`ifdef VGM_NES_SHORT_WAIT_EN
                            if (is_short_wait(bus.in_data)) begin
                                state_next = WAIT;
                            end
`endif
                        end
                    endcase
                end
            end
            FETCH_A0: begin
                if (accept) begin
                    state_next = FETCH_A1;
                end
            end
            FETCH_A1: begin
                if (accept) begin
                    if (is_wait) begin
                        state_next = ({bus.in_data, arg0} == 16'd0) ? FETCH_OP : WAIT;
                    end else if (arg0[7:4] == 4'h0) begin
                        state_next = WR_HI;
                    end else begin
                        state_next = FETCH_OP;
                    end
                end
            end
            WR_HI: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = WR_LO;
                end
            end
            WR_LO: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = FETCH_OP;
                end
            end
            WAIT: begin
                if (tick && (sample_cnt == 16'd1)) begin
                    state_next = FETCH_OP;
                end
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = FETCH_OP;
        endcase
    end

    // Argument latches, APU register/value outputs, sample down-counter and pulse counter.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            is_wait     <= 1'b0;
            arg0        <= 8'd0;
            bus.out_reg <= 4'd0;
            bus.out_val <= 8'd0;
            sample_cnt  <= 16'd0;
            pulse_cnt   <= '0;
        end else begin
            if ((state == FETCH_OP) && accept) begin
                is_wait <= (bus.in_data == OP_WAIT_N);
            end
            if ((state == FETCH_A0) && accept) begin
                arg0 <= bus.in_data;
            end
            if ((state == FETCH_A1) && accept && !is_wait && (arg0[7:4] == 4'h0)) begin
                bus.out_reg <= arg0[3:0];
                bus.out_val <= bus.in_data;
            end

            if ((state == FETCH_A1) && accept && is_wait) begin
                sample_cnt <= {bus.in_data, arg0};
            end
`ifdef VGM_NES_SHORT_WAIT_EN
            else if ((state == FETCH_OP) && accept) begin
                sample_cnt <= short_wait_samples(bus.in_data);
            end
`endif
            else if ((state == WAIT) && tick) begin
                sample_cnt <= sample_cnt - 16'd1;
            end

            if ((state == WR_HI) || (state == WR_LO)) begin
                pulse_cnt <= (pulse_cnt == PULSE_LAST) ? '0 : pulse_cnt + 1'b1;
            end else begin
                pulse_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vgm_nes_player.sv
// Directed self-checking bench for vgm_nes_player (CLK_PER_SAMPLE=4, WR_PULSE=2).
// Expected strobes and timings are hand-derived from the command streams fed in.
module tb_vgm_nes_player;

    localparam int CPS = 4;
    localparam int WP  = 2;

    logic in_clk = 1'b0;
    logic in_rst;
    logic in_enable;
    logic out_done;
    logic out_error;

    vgm_nes_player_if bus ();

    vgm_nes_player #(
        .CLK_PER_SAMPLE (CPS),
        .WR_PULSE       (WP)
    ) dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_enable (in_enable),
        .bus       (bus),
        .out_done  (out_done),
        .out_error (out_error)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] tx_q[$];
    int         acc_q[$];
    logic [3:0] sreg_q[$];
    logic [7:0] sval_q[$];
    int         rise_q[$];
    int         len_q[$];
    logic [3:0] exp_reg_q[$];
    logic [7:0] exp_val_q[$];
    logic       wr_prev = 1'b0;
    int         hi_len  = 0;

    // Free-running cycle counter used as the timebase for all latency checks.
    always @(posedge in_clk) cyc <= cyc + 1;

    // Record every write strobe: register, value, rise time and high duration.
    always @(negedge in_clk) begin
        if (bus.out_wr && !wr_prev) begin
            sreg_q.push_back(bus.out_reg);
            sval_q.push_back(bus.out_val);
            rise_q.push_back(cyc);
            hi_len = 0;
        end
        if (bus.out_wr) hi_len++;
        if (!bus.out_wr && wr_prev) len_q.push_back(hi_len);
        wr_prev = bus.out_wr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Feed tx_q into the stream, optionally with random valid gaps, within a cycle budget.
    task automatic applyStimulus(input int gap_pct, input int budget);
        while (tx_q.size() > 0 && budget > 0) begin
            @(negedge in_clk);
            budget--;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = tx_q[0];
                if (bus.out_ready) begin
                    acc_q.push_back(cyc);
                    void'(tx_q.pop_front());
                end
            end
        end
        if (tx_q.size() > 0) begin
            checkOutput("feed_timeout", tx_q.size(), 0);
            tx_q.delete();
        end
        @(negedge in_clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic doReset();
        @(posedge in_clk);
        #1;
        in_rst       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        in_enable    = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
        acc_q.delete();
        sreg_q.delete();
        sval_q.delete();
        rise_q.delete();
        len_q.delete();
        in_rst = 1'b0;
    endtask

    // Latency from the ak-th accepted byte to the rk-th strobe rise; -1 if either is missing.
    function automatic int latency(input int ak, input int rk);
        if (ak >= acc_q.size() || rk >= rise_q.size()) return -1;
        return rise_q[rk] - acc_q[ak];
    endfunction

    task automatic checkStrobes(input string tag);
        checkOutput({tag, "_count"}, sreg_q.size(), exp_reg_q.size());
        for (int k = 0; k < exp_reg_q.size() && k < sreg_q.size(); k++) begin
            checkOutput($sformatf("%s_reg%0d", tag, k), sreg_q[k], exp_reg_q[k]);
            checkOutput($sformatf("%s_val%0d", tag, k), sval_q[k], exp_val_q[k]);
        end
    endtask

    task automatic buildStream();
        tx_q.delete();
        exp_reg_q.delete();
        exp_val_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 4) begin
                tx_q.push_back(8'h61); tx_q.push_back(8'h02); tx_q.push_back(8'h00);
            end else if (i % 7 == 3) begin
                tx_q.push_back(8'hB4); tx_q.push_back(8'h17); tx_q.push_back(8'(i));
            end else begin
                tx_q.push_back(8'hB4);
                tx_q.push_back(8'(i % 16));
                tx_q.push_back(8'((i * 37 + 5) % 256));
                exp_reg_q.push_back(4'(i % 16));
                exp_val_q.push_back(8'((i * 37 + 5) % 256));
            end
        end
        tx_q.push_back(8'h66);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ready_seen;
        in_rst       = 1'b1;
        in_enable    = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge in_clk);

        // Reset state.
        checkOutput("rst_ready", bus.out_ready, 1'b0);
        checkOutput("rst_wr", bus.out_wr, 1'b0);
        checkOutput("rst_reg", bus.out_reg, 4'h0);
        checkOutput("rst_val", bus.out_val, 8'h00);
        checkOutput("rst_done", out_done, 1'b0);
        checkOutput("rst_error", out_error, 1'b0);
        doReset();
        settle(1);
        checkOutput("idle_ready", bus.out_ready, 1'b1);

        // Basic write then end of stream.
        tx_q = '{8'hB4, 8'h02, 8'h5A, 8'h66};
        applyStimulus(0, 200);
        settle(10);
        exp_reg_q = '{4'h2};
        exp_val_q = '{8'h5A};
        checkStrobes("basic");
        checkOutput("basic_hi_len", (len_q.size() > 0) ? len_q[0] : -1, WP);
        checkOutput("basic_lat", latency(2, 0), 1);
        checkOutput("basic_end_gap", (acc_q.size() > 3) ? acc_q[3] - acc_q[2] : -1, 1 + 2 * WP);
        checkOutput("basic_done", out_done, 1'b1);
        checkOutput("basic_ready", bus.out_ready, 1'b0);
        checkOutput("basic_error", out_error, 1'b0);

        // Out-of-range APU address is dropped silently.
        doReset();
        tx_q = '{8'hB4, 8'h15, 8'h0F, 8'hB4, 8'h00, 8'hBF};
        applyStimulus(0, 200);
        settle(10);
        exp_reg_q = '{4'h0};
        exp_val_q = '{8'hBF};
        checkStrobes("drop");
        checkOutput("drop_error", out_error, 1'b0);
        checkOutput("drop_done", out_done, 1'b0);

        // Wait of 3 samples adds 3*CPS cycles to the zero-wait latency of 4.
        doReset();
        tx_q = '{8'h61, 8'h03, 8'h00, 8'hB4, 8'h01, 8'h11};
        applyStimulus(0, 300);
        settle(10);
        checkOutput("wait3_lat", latency(2, 0), 4 + 3 * CPS);
        checkOutput("wait3_val", (sval_q.size() > 0) ? sval_q[0] : 8'hXX, 8'h11);

        doReset();
        tx_q = '{8'h61, 8'h00, 8'h00, 8'hB4, 8'h01, 8'h11};
        applyStimulus(0, 300);
        settle(10);
        checkOutput("wait0_lat", latency(2, 0), 4);

        // Pausing for 5 cycles during the wait extends it by exactly 5.
        doReset();
        tx_q = '{8'h61, 8'h03, 8'h00, 8'hB4, 8'h01, 8'h11};
        fork
            applyStimulus(0, 300);
            begin
                repeat (5) @(negedge in_clk);
                in_enable = 1'b0;
                repeat (5) @(negedge in_clk);
                in_enable = 1'b1;
            end
        join
        settle(10);
        checkOutput("pause_lat", latency(2, 0), 4 + 3 * CPS + 5);

        // Unsupported opcode is terminal until reset.
        doReset();
        tx_q = '{8'h50};
        applyStimulus(0, 50);
        settle(3);
        checkOutput("err_flag", out_error, 1'b1);
        checkOutput("err_done", out_done, 1'b0);
        ready_seen = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB4;
        repeat (8) begin
            @(negedge in_clk);
            if (bus.out_ready) ready_seen++;
        end
        bus.in_valid = 1'b0;
        checkOutput("err_ready_stuck", ready_seen, 0);
        doReset();
        settle(1);
        checkOutput("err_cleared", out_error, 1'b0);

`ifdef VGM_NES_SHORT_WAIT_EN
        // 0x62 waits 735 samples, 0x70 waits one sample.
        doReset();
        tx_q = '{8'h62, 8'hB4, 8'h01, 8'h22};
        applyStimulus(0, 5000);
        settle(10);
        checkOutput("w60_lat", latency(0, 0), 735 * CPS + 4);
        checkOutput("w60_error", out_error, 1'b0);
        doReset();
        tx_q = '{8'h70, 8'hB4, 8'h01, 8'h33};
        applyStimulus(0, 200);
        settle(10);
        checkOutput("w70_lat", latency(0, 0), CPS + 4);
`else
        // Short wait opcodes are unsupported in the default build.
        doReset();
        tx_q = '{8'h62};
        applyStimulus(0, 50);
        settle(3);
        checkOutput("w60_error", out_error, 1'b1);
        doReset();
        tx_q = '{8'h70};
        applyStimulus(0, 50);
        settle(3);
        checkOutput("w70_error", out_error, 1'b1);
`endif

        // Asynchronous reset in the middle of the high phase drops out_wr at once.
        doReset();
        tx_q = '{8'hB4, 8'h03, 8'h77};
        applyStimulus(0, 100);
        checkOutput("mid_wr_high", bus.out_wr, 1'b1);
        #2;
        in_rst = 1'b1;
        #1;
        checkOutput("mid_wr_drop", bus.out_wr, 1'b0);
        checkOutput("mid_reg_clr", bus.out_reg, 4'h0);
        doReset();
        settle(1);
        checkOutput("mid_ready", bus.out_ready, 1'b1);

        // 20-command stream, gapless then with random valid gaps: same strobes.
        doReset();
        buildStream();
        applyStimulus(0, 2000);
        settle(20);
        checkStrobes("stream");
        checkOutput("stream_done", out_done, 1'b1);

        doReset();
        buildStream();
        applyStimulus(30, 4000);
        settle(20);
        checkStrobes("gaps");
        checkOutput("gaps_done", out_done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
